// File: rtl/somador_pkg.sv
// Shared types and elaboration helpers for the chunked sequential adder/subtractor.
package somador_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Number of clock cycles (chunks) needed for one operation.
  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  function automatic bit chunk_ok(input int width, input int chunk);
    return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
  endfunction

  // Chunk counter width; a single-chunk build still gets a 1-bit counter.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/somador_sequencial_if.sv
// Request/result bundle of the sequential adder: operands and start in, status and result out.
interface somador_sequencial_if #(
  parameter int WIDTH = 16
);

  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, s, cout, ovf
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, s, cout, ovf
  );

endinterface

// File: rtl/somador_bloco.sv
// Combinational CHUNK-bit ripple adder; also exposes the carry into its MSB for overflow detection.
module somador_bloco #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  // Each stage keeps its own carry nets so the chain is not one self-referencing vector.
  for (genvar gi = 0; gi < CHUNK; gi++) begin : g_bit
    logic ci;
    logic co;

    if (gi == 0) begin : g_first
      assign ci = cin;
    end else begin : g_next
      assign ci = g_bit[gi-1].co;
    end

    assign s[gi] = a[gi] ^ b[gi] ^ ci;
    assign co    = (a[gi] & b[gi]) | (ci & (a[gi] ^ b[gi]));
  end

  assign cout  = g_bit[CHUNK-1].co;
  assign c_msb = g_bit[CHUNK-1].ci;

endmodule

// File: rtl/somador_sequencial.sv
// Multi-cycle WIDTH-bit adder/subtractor: one CHUNK-bit adder reused LSB chunk first,
// with a registered carry between chunks and a start/busy/done handshake.
module somador_sequencial
  import somador_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  somador_sequencial_if.slave bus
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int IDXW   = idx_width(NCHUNK);

  localparam logic [0:0] ST_IDLE = IDLE;
  localparam logic [0:0] ST_RUN  = RUN;

  if (!chunk_ok(WIDTH, CHUNK)) begin : g_cfg_err
    $error("somador_sequencial: WIDTH must be a non-zero multiple of CHUNK");
  end

  logic [0:0]       state_reg;
  logic [IDXW-1:0]  idx_reg;
  logic [WIDTH-1:0] op_a_reg;
  logic [WIDTH-1:0] op_b_reg;
  logic             carry_reg;
  logic [WIDTH-1:0] s_reg;
  logic             cout_reg;
  logic             ovf_reg;
  logic             busy_reg;
  logic             done_reg;

  logic [CHUNK-1:0] a_chunks [NCHUNK];
  logic [CHUNK-1:0] b_chunks [NCHUNK];
  logic [CHUNK-1:0] chunk_a;
  logic [CHUNK-1:0] chunk_b;
  logic [CHUNK-1:0] chunk_sum;
  logic             chunk_cout;
  logic             chunk_cmsb;
  logic             last_chunk;

  for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunk
    assign a_chunks[gi] = op_a_reg[gi*CHUNK +: CHUNK];
    assign b_chunks[gi] = op_b_reg[gi*CHUNK +: CHUNK];
  end

  assign chunk_a    = a_chunks[idx_reg];
  assign chunk_b    = b_chunks[idx_reg];
  assign last_chunk = (idx_reg == IDXW'(NCHUNK - 1));

  somador_bloco #(
    .CHUNK (CHUNK)
  ) u_bloco (
    .a     (chunk_a),
    .b     (chunk_b),
    .cin   (carry_reg),
    .s     (chunk_sum),
    .cout  (chunk_cout),
    .c_msb (chunk_cmsb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      idx_reg   <= '0;
      op_a_reg  <= '0;
      op_b_reg  <= '0;
      carry_reg <= 1'b0;
      s_reg     <= '0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (bus.start) begin
            // Subtraction is a + ~b + 1: invert B here and seed the carry with 1.
            state_reg <= ST_RUN;
            idx_reg   <= '0;
            op_a_reg  <= bus.a;
            op_b_reg  <= bus.sub ? ~bus.b : bus.b;
            carry_reg <= bus.sub | bus.cin;
            busy_reg  <= 1'b1;
          end
        end
        ST_RUN: begin
          s_reg[idx_reg*CHUNK +: CHUNK] <= chunk_sum;
          carry_reg <= chunk_cout;
          idx_reg   <= idx_reg + IDXW'(1);
          if (last_chunk) begin
            state_reg <= ST_IDLE;
            cout_reg  <= chunk_cout;
            ovf_reg   <= chunk_cmsb ^ chunk_cout;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
  assign bus.s    = s_reg;
  assign bus.cout = cout_reg;
  assign bus.ovf  = ovf_reg;

endmodule

// File: tb/tb_somador_sequencial.sv
// Self-checking bench: directed handshake cases on a CHUNK=4 build, then random ops run
// in parallel on CHUNK=4, CHUNK=16 and CHUNK=1 builds against an arithmetic reference.
module tb_somador_sequencial;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  somador_sequencial_if #(.WIDTH(16)) if4 ();
  somador_sequencial_if #(.WIDTH(16)) if16 ();
  somador_sequencial_if #(.WIDTH(16)) if1 ();

  somador_sequencial #(.WIDTH(16), .CHUNK(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
  somador_sequencial #(.WIDTH(16), .CHUNK(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave));
  somador_sequencial #(.WIDTH(16), .CHUNK(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference from plain integer arithmetic: returns {ovf, cout, s}.
  function automatic logic [17:0] ref_model(input logic [15:0] a, input logic [15:0] b,
                                            input logic cin, input logic sub);
    int          ua;
    int          ub;
    int          sa;
    int          sb;
    int          ur;
    int          sr;
    logic        c;
    logic        o;
    logic [15:0] r;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sub) begin
      ur = ua - ub;
      sr = sa - sb;
      c  = (ua >= ub);
    end else begin
      ur = ua + ub + int'(cin);
      sr = sa + sb + int'(cin);
      c  = (ur > 65535);
    end
    r = ur[15:0];
    o = (sr > 32767) || (sr < -32768);
    return {o, c, r};
  endfunction

  task automatic set_ops(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
    if4.a = a;  if4.b = b;  if4.cin = cin;  if4.sub = sub;
    if16.a = a; if16.b = b; if16.cin = cin; if16.sub = sub;
    if1.a = a;  if1.b = b;  if1.cin = cin;  if1.sub = sub;
  endtask

  // Called at the negedge right after the accepting edge; returns cycles until done.
  task automatic wait_done4(input string tag, output int lat);
    lat = 0;
    while (!if4.done && lat < 20) begin
      chk_eq({tag, "_busy"}, 32'(if4.busy), 32'd1);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run4(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic cin, input logic sub,
                      input logic [15:0] exp_s, input logic exp_c, input logic exp_o);
    int lat;
    chk_eq({tag, "_idle"}, 32'(if4.busy), 32'd0);
    set_ops(a, b, cin, sub);
    if4.start = 1'b1;
    @(negedge clk);
    if4.start = 1'b0;
    set_ops($urandom, $urandom, 1'b0, 1'b0);
    wait_done4(tag, lat);
    chk_eq({tag, "_lat"}, 32'(lat), 32'd4);
    chk_eq({tag, "_s"}, 32'(if4.s), 32'(exp_s));
    chk_eq({tag, "_cout"}, 32'(if4.cout), 32'(exp_c));
    chk_eq({tag, "_ovf"}, 32'(if4.ovf), 32'(exp_o));
    chk_eq({tag, "_busy_end"}, 32'(if4.busy), 32'd0);
    $display("%s: sub=%0d a=%h b=%h cin=%0d -> s=%h cout=%0d ovf=%0d lat=%0d",
             tag, sub, a, b, cin, if4.s, if4.cout, if4.ovf, lat);
    @(negedge clk);
    chk_eq({tag, "_done_pulse"}, 32'(if4.done), 32'd0);
  endtask

  initial begin
    int          lat;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rc;
    logic        rs;
    logic [17:0] expv;

    if4.start = 1'b0;
    if16.start = 1'b0;
    if1.start = 1'b0;
    set_ops('0, '0, 1'b0, 1'b0);

    // Reset state
    repeat (3) @(negedge clk);
    chk_eq("rst_busy", 32'(if4.busy), 32'd0);
    chk_eq("rst_done", 32'(if4.done), 32'd0);
    chk_eq("rst_s", 32'(if4.s), 32'd0);
    chk_eq("rst_cout", 32'(if4.cout), 32'd0);
    chk_eq("rst_ovf", 32'(if4.ovf), 32'd0);
    chk_eq("rst_s16", 32'(if16.s), 32'd0);
    chk_eq("rst_s1", 32'(if1.s), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed arithmetic cases
    run4("t1_add",   16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0);
    run4("t1_cin",   16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0);
    run4("t2_sub_lt", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run4("t2_sub_gt", 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
    run4("t3_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run4("t3_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);

    // Start while busy is ignored, then back-to-back start on the done cycle
    set_ops(16'h1111, 16'h2222, 1'b0, 1'b0);
    if4.start = 1'b1;
    @(negedge clk);
    if4.start = 1'b0;
    @(negedge clk);
    set_ops(16'hAAAA, 16'h5555, 1'b1, 1'b1);
    if4.start = 1'b1;
    @(negedge clk);
    if4.start = 1'b0;
    chk_eq("t4_busy_mid", 32'(if4.busy), 32'd1);
    @(negedge clk);
    chk_eq("t4_no_early_done", 32'(if4.done), 32'd0);
    @(negedge clk);
    chk_eq("t4_done", 32'(if4.done), 32'd1);
    chk_eq("t4_s", 32'(if4.s), 32'h3333);
    chk_eq("t4_cout", 32'(if4.cout), 32'd0);
    $display("t4_ignore: s=%h cout=%0d ovf=%0d", if4.s, if4.cout, if4.ovf);
    set_ops(16'h7000, 16'h1000, 1'b0, 1'b0);
    if4.start = 1'b1;
    @(negedge clk);
    if4.start = 1'b0;
    chk_eq("t4_b2b_done_low", 32'(if4.done), 32'd0);
    wait_done4("t4_b2b", lat);
    chk_eq("t4_b2b_lat", 32'(lat), 32'd4);
    chk_eq("t4_b2b_s", 32'(if4.s), 32'h8000);
    chk_eq("t4_b2b_ovf", 32'(if4.ovf), 32'd1);
    $display("t4_b2b: s=%h cout=%0d ovf=%0d lat=%0d", if4.s, if4.cout, if4.ovf, lat);
    @(negedge clk);

    // Reset in the middle of an operation
    set_ops(16'h1234, 16'h0001, 1'b0, 1'b0);
    if4.start = 1'b1;
    @(negedge clk);
    if4.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_eq("t5_busy", 32'(if4.busy), 32'd0);
    chk_eq("t5_done", 32'(if4.done), 32'd0);
    chk_eq("t5_s", 32'(if4.s), 32'd0);
    chk_eq("t5_ovf", 32'(if4.ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk_eq("t5_no_done", 32'(if4.done), 32'd0);
    end
    $display("t5_reset: aborted op, busy=%0d s=%h", if4.busy, if4.s);
    run4("t5_after", 16'h0F0F, 16'h00F1, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0);

    // Random ops on all three builds at once
    for (int n = 0; n < 1000; n++) begin
      int          l4;
      int          l16;
      int          l1;
      logic [17:0] g4;
      logic [17:0] g16;
      logic [17:0] g1;
      ra = ($urandom_range(0, 9) == 0) ? 16'h7FFF : 16'($urandom);
      rb = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom);
      rc = 1'($urandom);
      rs = 1'($urandom);
      expv = ref_model(ra, rb, rc, rs);
      set_ops(ra, rb, rc, rs);
      if4.start = 1'b1;
      if16.start = 1'b1;
      if1.start = 1'b1;
      @(negedge clk);
      if4.start = 1'b0;
      if16.start = 1'b0;
      if1.start = 1'b0;
      set_ops(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      l4 = -1; l16 = -1; l1 = -1;
      g4 = '0; g16 = '0; g1 = '0;
      for (int k = 1; k <= 20 && (l4 < 0 || l16 < 0 || l1 < 0); k++) begin
        @(negedge clk);
        if (if4.done && l4 < 0) begin l4 = k; g4 = {if4.ovf, if4.cout, if4.s}; end
        if (if16.done && l16 < 0) begin l16 = k; g16 = {if16.ovf, if16.cout, if16.s}; end
        if (if1.done && l1 < 0) begin l1 = k; g1 = {if1.ovf, if1.cout, if1.s}; end
      end
      chk_eq("rnd_lat4", 32'(l4), 32'd4);
      chk_eq("rnd_lat16", 32'(l16), 32'd1);
      chk_eq("rnd_lat1", 32'(l1), 32'd16);
      chk_eq("rnd_res4", 32'(g4), 32'(expv));
      chk_eq("rnd_res16", 32'(g16), 32'(expv));
      chk_eq("rnd_res1", 32'(g1), 32'(expv));
      $display("rnd %0d: sub=%0d a=%h b=%h cin=%0d exp=%h got4=%h got16=%h got1=%h",
               n, rs, ra, rb, rc, expv, g4, g16, g1);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
